// File: rtl/reg_file_mc_pkg.sv
// reg_file_mc_pkg: register map, STA bit indices and interrupt FSM states for reg_file_mc
package reg_file_mc_pkg;
  localparam int unsigned VER_A       = 'h00;
  localparam int unsigned SCR_A       = 'h04;
  localparam int unsigned CTRL_A      = 'h08;
  localparam int unsigned IMR_A       = 'h0C;
  localparam int unsigned STA_A       = 'h10;
  localparam int unsigned UCTR_A      = 'h18;
  localparam int unsigned CH_BASE     = 'h40;
  localparam int unsigned CH_STRIDE   = 'h20;
  localparam int unsigned CH_H2U_ADDR = 'h0;
  localparam int unsigned CH_H2U_LEN  = 'h4;
  localparam int unsigned CH_U2H_ADDR = 'h8;
  localparam int unsigned CH_U2H_LEN  = 'hC;
  localparam int USR_INTR_BIT = 16;
  localparam int ZLEN_ERR_BIT = 17;
  typedef enum logic [1:0] {IDLE, REQ, WAIT_CLR} irq_st_e;
endpackage

// File: rtl/reg_file_ch.sv
// reg_file_ch: per-channel address/length registers with decode and read mux
module reg_file_ch
  import reg_file_mc_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE = '0
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic [31:0]       h2u_addr,
  output logic [31:0]       h2u_len,
  output logic [31:0]       u2h_addr,
  output logic [31:0]       u2h_len,
  output logic [31:0]       rd_data
);
  logic hit;
  logic [3:0] off;
  // bit 4 of every channel base is 0, so offsets 0x10-0x1C fall out of the match
  assign hit = addr[ADDR_W-1:4] == BASE[ADDR_W-1:4];
  assign off = addr[3:0];
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      h2u_addr <= '0;
      h2u_len  <= '0;
      u2h_addr <= '0;
      u2h_len  <= '0;
    end else if (wr && hit) begin
      if (off == 4'(CH_H2U_ADDR)) h2u_addr <= data;
      if (off == 4'(CH_H2U_LEN))  h2u_len  <= data;
      if (off == 4'(CH_U2H_ADDR)) u2h_addr <= data;
      if (off == 4'(CH_U2H_LEN))  u2h_len  <= data;
    end
  end
  always_comb begin
    rd_data = !hit ? '0 :
              off == 4'(CH_H2U_ADDR) ? h2u_addr :
              off == 4'(CH_H2U_LEN)  ? h2u_len  :
              off == 4'(CH_U2H_ADDR) ? u2h_addr :
              off == 4'(CH_U2H_LEN)  ? u2h_len  : '0;
  end
endmodule

// File: rtl/reg_file_mc.sv
// reg_file_mc: global PCIe register file for a multi-channel DMA engine
module reg_file_mc
  import reg_file_mc_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter logic [31:0] VER = 32'h0001_0000,
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [31:0]           data_i,
  input  logic                  data_valid_i,
  output logic                  fpga_reg_wr_ack_o,
  input  logic                  fpga_reg_rd_i,
  output logic                  fpga_reg_rd_ack_o,
  output logic [31:0]           data_o,
  output logic [NUM_CH-1:0]     h2u_en_o,
  output logic [32*NUM_CH-1:0]  h2u_addr_o,
  output logic [32*NUM_CH-1:0]  h2u_len_o,
  input  logic [NUM_CH-1:0]     h2u_done_i,
  output logic [NUM_CH-1:0]     u2h_en_o,
  output logic [32*NUM_CH-1:0]  u2h_addr_o,
  output logic [32*NUM_CH-1:0]  u2h_len_o,
  input  logic [NUM_CH-1:0]     u2h_done_i,
  output logic                  intr_req_o,
  input  logic                  intr_req_done_i,
  input  logic                  user_intr_req_i,
  output logic                  user_intr_ack_o,
  output logic                  user_reset_o
);
  localparam logic [31:0] CM = 32'((64'd1 << (2 * NUM_CH)) - 64'd1);
  localparam logic [31:0] SM = CM | 32'h0003_0000;
  logic dv_d1, wr_stb, wr_scr, wr_ctrl, wr_imr, wr_sta, wr_uctr;
  logic [31:0] scr, ctrl, imr, sta, uctr, ctrl_n, sta_n, sta_set, done, len_nz, ch_or, rd_data;
  logic [31:0] ch_rd [NUM_CH];
  irq_st_e state, state_n;
  assign wr_stb  = data_valid_i & ~dv_d1;
  assign wr_scr  = wr_stb & (addr_i == ADDR_W'(SCR_A));
  assign wr_ctrl = wr_stb & (addr_i == ADDR_W'(CTRL_A));
  assign wr_imr  = wr_stb & (addr_i == ADDR_W'(IMR_A));
  assign wr_sta  = wr_stb & (addr_i == ADDR_W'(STA_A));
  assign wr_uctr = wr_stb & (addr_i == ADDR_W'(UCTR_A));
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    reg_file_ch #(.ADDR_W(ADDR_W), .BASE(ADDR_W'(CH_BASE + CH_STRIDE * c))) u_ch (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .wr      (wr_stb),
      .addr    (addr_i),
      .data    (data_i),
      .h2u_addr(h2u_addr_o[32*c +: 32]),
      .h2u_len (h2u_len_o[32*c +: 32]),
      .u2h_addr(u2h_addr_o[32*c +: 32]),
      .u2h_len (u2h_len_o[32*c +: 32]),
      .rd_data (ch_rd[c])
    );
    assign h2u_en_o[c] = ctrl[2*c];
    assign u2h_en_o[c] = ctrl[2*c+1];
  end
  always_comb begin
    done   = '0;
    len_nz = '0;
    ch_or  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      done[2*i]     = h2u_done_i[i];
      done[2*i+1]   = u2h_done_i[i];
      len_nz[2*i]   = |h2u_len_o[32*i +: 32];
      len_nz[2*i+1] = |u2h_len_o[32*i +: 32];
      ch_or         = ch_or | ch_rd[i];
    end
    sta_set = done;
    sta_set[USR_INTR_BIT] = user_intr_req_i & ~sta[USR_INTR_BIT];
    sta_set[ZLEN_ERR_BIT] = wr_ctrl & |(data_i & CM & ~len_nz);
    // set-writes land after done clears, and set events after W1C, so the set always wins
    ctrl_n  = (ctrl & ~done) | (wr_ctrl ? data_i & len_nz : '0);
    sta_n   = (sta & ~(wr_sta ? data_i : '0)) | sta_set;
    rd_data = addr_i == ADDR_W'(VER_A)  ? VER  :
              addr_i == ADDR_W'(SCR_A)  ? scr  :
              addr_i == ADDR_W'(CTRL_A) ? ctrl :
              addr_i == ADDR_W'(IMR_A)  ? imr  :
              addr_i == ADDR_W'(STA_A)  ? sta  :
              addr_i == ADDR_W'(UCTR_A) ? uctr : ch_or;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      dv_d1             <= 1'b0;
      fpga_reg_wr_ack_o <= 1'b0;
      fpga_reg_rd_ack_o <= 1'b0;
      data_o            <= '0;
      user_intr_ack_o   <= 1'b0;
      scr               <= '0;
      ctrl              <= '0;
      imr               <= '0;
      sta               <= '0;
      uctr              <= '0;
    end else begin
      dv_d1             <= data_valid_i;
      fpga_reg_wr_ack_o <= wr_stb;
      fpga_reg_rd_ack_o <= fpga_reg_rd_i;
      if (fpga_reg_rd_i) data_o <= rd_data;
      user_intr_ack_o   <= wr_sta & data_i[USR_INTR_BIT] & sta[USR_INTR_BIT];
      ctrl              <= ctrl_n;
      sta               <= sta_n;
      if (wr_scr)  scr  <= data_i;
      if (wr_imr)  imr  <= data_i & SM;
      if (wr_uctr) uctr <= data_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && |(sta & imr))                 state_n = REQ;
    if (state == REQ && intr_req_done_i)               state_n = WAIT_CLR;
    if (state != IDLE && state != REQ && wr_sta)       state_n = IDLE;
  end
  assign intr_req_o   = state == REQ;
  assign user_reset_o = uctr[0];
endmodule

// File: tb/tb_reg_file_mc.sv
// tb_reg_file_mc: scoreboard bench for reg_file_mc against a behavioural register model
module tb_reg_file_mc;
  localparam int NC = 4;
  localparam int AW = 10;
  localparam logic [31:0] VERV = 32'h0001_0000;
  localparam logic [31:0] SMASK = 32'h0003_00FF;
  logic clk_i = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [31:0] data_i = '0, data_o;
  logic data_valid_i = 1'b0, fpga_reg_rd_i = 1'b0, fpga_reg_wr_ack_o, fpga_reg_rd_ack_o;
  logic [NC-1:0] h2u_en_o, u2h_en_o, h2u_done_i = '0, u2h_done_i = '0;
  logic [32*NC-1:0] h2u_addr_o, h2u_len_o, u2h_addr_o, u2h_len_o;
  logic intr_req_o, intr_req_done_i = 1'b0, user_intr_req_i = 1'b0, user_intr_ack_o, user_reset_o;
  int errors = 0, checks = 0;
  logic [31:0] exp_q [$];
  logic [31:0] m_scr, m_imr, m_sta, m_uctr;
  logic [31:0] m_hadr [NC], m_hlen [NC], m_uadr [NC], m_ulen [NC];
  bit m_hen [NC], m_uen [NC];

  reg_file_mc #(.NUM_CH(NC), .VER(VERV), .ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .addr_i(addr_i), .data_i(data_i), .data_valid_i(data_valid_i),
    .fpga_reg_wr_ack_o(fpga_reg_wr_ack_o), .fpga_reg_rd_i(fpga_reg_rd_i),
    .fpga_reg_rd_ack_o(fpga_reg_rd_ack_o), .data_o(data_o),
    .h2u_en_o(h2u_en_o), .h2u_addr_o(h2u_addr_o), .h2u_len_o(h2u_len_o), .h2u_done_i(h2u_done_i),
    .u2h_en_o(u2h_en_o), .u2h_addr_o(u2h_addr_o), .u2h_len_o(u2h_len_o), .u2h_done_i(u2h_done_i),
    .intr_req_o(intr_req_o), .intr_req_done_i(intr_req_done_i), .user_intr_req_i(user_intr_req_i),
    .user_intr_ack_o(user_intr_ack_o), .user_reset_o(user_reset_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // read-data monitor: every acknowledged read is matched against the oldest expectation
  always @(negedge clk_i) begin
    if (fpga_reg_rd_ack_o) begin
      if (exp_q.size() == 0) chk("rd_unexpected_ack", 1, 0);
      else chk("rd_data", data_o, exp_q.pop_front());
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic m_reset;
    m_scr = 0; m_imr = 0; m_sta = 0; m_uctr = 0;
    for (int c = 0; c < NC; c++) begin
      m_hadr[c] = 0; m_hlen[c] = 0; m_uadr[c] = 0; m_ulen[c] = 0; m_hen[c] = 0; m_uen[c] = 0;
    end
  endtask

  function automatic bit ch_dec(input int unsigned a, output int c, output int o);
    c = int'((a - 64) / 32);
    o = int'(((a - 64) % 32) / 4);
    return a >= 64 && a < 64 + 32 * NC && a % 4 == 0 && (a - 64) % 32 < 16;
  endfunction

  function automatic logic [31:0] m_rd(input int unsigned a);
    logic [31:0] r;
    int c, o;
    r = 0;
    if (a == 'h00) r = VERV;
    if (a == 'h04) r = m_scr;
    if (a == 'h08) for (int i = 0; i < NC; i++) r = r | (32'(m_hen[i]) << (2*i)) | (32'(m_uen[i]) << (2*i+1));
    if (a == 'h0C) r = m_imr;
    if (a == 'h10) r = m_sta;
    if (a == 'h18) r = m_uctr;
    if (ch_dec(a, c, o)) r = o == 0 ? m_hadr[c] : o == 1 ? m_hlen[c] : o == 2 ? m_uadr[c] : m_ulen[c];
    return r;
  endfunction

  task automatic m_wr(input int unsigned a, input logic [31:0] d);
    int c, o;
    if (a == 'h04) m_scr = d;
    if (a == 'h0C) m_imr = d & SMASK;
    if (a == 'h10) m_sta = m_sta & ~d;
    if (a == 'h18) m_uctr = d;
    if (a == 'h08)
      for (int i = 0; i < NC; i++) begin
        if (d[2*i])   begin if (m_hlen[i] != 0) m_hen[i] = 1; else m_sta[17] = 1; end
        if (d[2*i+1]) begin if (m_ulen[i] != 0) m_uen[i] = 1; else m_sta[17] = 1; end
      end
    if (ch_dec(a, c, o)) begin
      if (o == 0) m_hadr[c] = d;
      if (o == 1) m_hlen[c] = d;
      if (o == 2) m_uadr[c] = d;
      if (o == 3) m_ulen[c] = d;
    end
  endtask

  task automatic wr(input int unsigned a, input logic [31:0] d);
    bit uack;
    uack = a == 'h10 && d[16] && m_sta[16];
    addr_i = AW'(a); data_i = d; data_valid_i = 1;
    tick;
    chk("wr_ack", fpga_reg_wr_ack_o, 1);
    chk("user_intr_ack", user_intr_ack_o, uack);
    data_valid_i = 0;
    tick;
    m_wr(a, d);
  endtask

  task automatic rd(input int unsigned a, input int n = 1);
    for (int i = 0; i < n; i++) exp_q.push_back(m_rd(a));
    addr_i = AW'(a); fpga_reg_rd_i = 1;
    tick;
    chk("rd_ack", fpga_reg_rd_ack_o, 1);
    for (int i = 1; i < n; i++) tick;
    fpga_reg_rd_i = 0;
    tick;
  endtask

  task automatic done_p(input bit u2h, input int c);
    if (u2h) u2h_done_i[c] = 1; else h2u_done_i[c] = 1;
    tick;
    u2h_done_i = '0; h2u_done_i = '0;
    if (u2h) m_uen[c] = 0; else m_hen[c] = 0;
    m_sta[2*c + int'(u2h)] = 1;
  endtask

  task automatic user_p;
    user_intr_req_i = 1;
    tick;
    user_intr_req_i = 0;
    m_sta[16] = 1;
  endtask

  task automatic chk_out;
    logic [NC-1:0] he, ue;
    logic [32*NC-1:0] ha, hl, ua, ul;
    for (int c = 0; c < NC; c++) begin
      he[c] = m_hen[c]; ue[c] = m_uen[c];
      ha[32*c +: 32] = m_hadr[c]; hl[32*c +: 32] = m_hlen[c];
      ua[32*c +: 32] = m_uadr[c]; ul[32*c +: 32] = m_ulen[c];
    end
    chk("h2u_en", h2u_en_o, he);
    chk("u2h_en", u2h_en_o, ue);
    chk("h2u_addr", h2u_addr_o, ha);
    chk("h2u_len", h2u_len_o, hl);
    chk("u2h_addr", u2h_addr_o, ua);
    chk("u2h_len", u2h_len_o, ul);
    chk("user_reset", user_reset_o, m_uctr[0]);
  endtask

  task automatic wait_intr(input string name, input bit lvl, input int n);
    for (int i = 0; i < n && intr_req_o !== lvl; i++) tick;
    chk(name, intr_req_o, lvl);
  endtask

  function automatic int unsigned rnd_addr();
    int unsigned top [10] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h1C, 'h20, 'h3C};
    if ($urandom_range(0, 1) == 0) return top[$urandom_range(0, 9)];
    return 'h40 + 32 * $urandom_range(0, NC) + 4 * $urandom_range(0, 7);
  endfunction

  initial begin
    m_reset;
    repeat (3) tick;
    rst_n = 1;
    chk_out;
    chk("rst_intr_req", intr_req_o, 0);
    chk("rst_wr_ack", fpga_reg_wr_ack_o, 0);
    chk("rst_rd_ack", fpga_reg_rd_ack_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_user_ack", user_intr_ack_o, 0);
    rd('h00); rd('h04); rd('h08); rd('h10); rd('h40);
    rd('h00, 3);
    // channel 2 start and completion
    wr('h84, 32'h1000);
    wr('h80, 32'hA000_0000);
    wr('h08, 32'h10);
    chk("ch2_h2u_en", h2u_en_o[2], 1);
    chk("ch2_h2u_addr", h2u_addr_o[95:64], 32'hA000_0000);
    chk_out;
    done_p(0, 2);
    chk("ch2_en_after_done", h2u_en_o[2], 0);
    rd('h10);
    rd('h84);
    // zero-length start
    wr('h08, 32'h02);
    chk("zlen_u2h_en0", u2h_en_o[0], 0);
    rd('h10);
    rd('h08);
    // interrupt handshake
    wr('h10, 32'h0002_0010);
    wr('h0C, 32'h10);
    wr('h08, 32'h10);
    done_p(0, 2);
    wait_intr("intr_rise", 1, 5);
    intr_req_done_i = 1;
    tick;
    intr_req_done_i = 0;
    chk("intr_fall", intr_req_o, 0);
    tick;
    chk("intr_wait_clr", intr_req_o, 0);
    wr('h10, 32'h10);
    tick;
    chk("intr_after_clr", intr_req_o, 0);
    rd('h10);
    // masked source, then unmasking re-raises from IDLE
    wr('h0C, 32'h0);
    wr('h08, 32'h10);
    done_p(0, 2);
    repeat (4) tick;
    chk("intr_masked", intr_req_o, 0);
    rd('h10);
    wr('h0C, 32'h10);
    wait_intr("intr_unmask_rise", 1, 5);
    intr_req_done_i = 1;
    tick;
    intr_req_done_i = 0;
    wr('h10, 32'h10);
    wr('h0C, 32'h0);
    // W1C colliding with a done on the same bit
    done_p(0, 2);
    addr_i = AW'('h10); data_i = 32'h10; data_valid_i = 1; h2u_done_i[2] = 1;
    tick;
    chk("w1c_collide_wr_ack", fpga_reg_wr_ack_o, 1);
    data_valid_i = 0; h2u_done_i = '0;
    tick;
    rd('h10);
    // CTRL set-write colliding with a done on the same bit
    addr_i = AW'('h08); data_i = 32'h10; data_valid_i = 1; h2u_done_i[2] = 1;
    tick;
    data_valid_i = 0; h2u_done_i = '0;
    tick;
    m_hen[2] = 1; m_sta[4] = 1;
    chk_out;
    rd('h08);
    // user interrupt request and acknowledge
    user_p;
    rd('h10);
    wr('h10, 32'h0001_0000);
    wr('h10, 32'h0001_0000);
    rd('h10);
    wr('h18, 32'h1);
    chk_out;
    wr('h00, 32'hFFFF_FFFF);
    wr('h14, 32'hFFFF_FFFF);
    wr('h50, 32'hFFFF_FFFF);
    rd('h00); rd('h14); rd('h50);
    // randomized traffic
    for (int it = 0; it < 300; it++) begin
      int op, c, o;
      logic [31:0] d;
      op = $urandom_range(0, 9);
      if (op == 0) begin
        c = $urandom_range(0, NC - 1);
        o = $urandom_range(0, 3);
        d = (o % 2 == 1 && $urandom_range(0, 2) == 0) ? 32'h0 : $urandom;
        wr('h40 + 32 * c + 4 * o, d);
      end
      if (op == 1) wr('h08, $urandom_range(0, 1) ? ($urandom & 32'hFF) : $urandom);
      if (op == 2) wr('h10, $urandom);
      if (op == 3) wr('h0C, $urandom);
      if (op == 4) wr(rnd_addr(), $urandom);
      if (op == 5) done_p(1'($urandom_range(0, 1)), $urandom_range(0, NC - 1));
      if (op == 6) user_p;
      if (op == 7 || op == 8) rd(rnd_addr(), $urandom_range(1, 2));
      if (op == 9) chk_out;
    end
    rd('h10); rd('h08); rd('h0C);
    chk_out;
    // mid-operation reset
    wr('h44, 32'h100);
    wr('h4C, 32'h200);
    wr('h08, 32'h03);
    done_p(0, 1);
    wr('h0C, 32'hFF);
    wait_intr("intr_before_reset", 1, 5);
    rst_n = 0;
    tick;
    m_reset;
    chk("mid_rst_h2u_en", h2u_en_o, 0);
    chk("mid_rst_u2h_en", u2h_en_o, 0);
    chk("mid_rst_intr_req", intr_req_o, 0);
    rst_n = 1;
    tick;
    chk_out;
    rd('h10); rd('h08); rd('h0C); rd('h44);
    repeat (3) tick;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
